// File: rtl/fir_tap_mac_pkg.sv
// Shared definitions for the sequential FIR tap engine.
// Default widths and the controller state encoding.
package fir_tap_mac_pkg;

    localparam int NTAPS_DEF = 8;
    localparam int DW_DEF    = 8;
    localparam int CW_DEF    = 8;
    localparam int PW_DEF    = 16;
    localparam int AW_DEF    = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fir_tap_mac_delay_line.sv
// Sample delay line: shift register with shift enable, sync clear, indexed read.
// Ports: clk, clr, shift_en, din -> d[0]; rd_idx selects rd_data = d[rd_idx].
module fir_delay_line #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic [W-1:0]         din,
    input  logic [$clog2(N)-1:0] rd_idx,
    output logic [W-1:0]         rd_data
);

    logic [W-1:0] d_q [N];
    logic [W-1:0] d_d [N];

    always_comb begin
        d_d = d_q;
        if (clr) begin
            for (int i = 0; i < N; i++) d_d[i] = '0;
        end else if (shift_en) begin
            d_d[0] = din;
            for (int i = 1; i < N; i++) d_d[i] = d_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    assign rd_data = d_q[rd_idx];

endmodule

// File: rtl/fir_tap_mac.sv
// Sequential FIR tap engine: one tap per cycle through an external multiplier.
// Ports: in_* sample input, coef_* coefficient writes, mult_* multiplier link, out_* result.
module fir_tap_mac
    import fir_tap_mac_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int PW    = PW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_sample,
    output logic          in_ready,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic          coef_err,
    output logic [DW-1:0] mult_sample,
    output logic [CW-1:0] mult_coeff,
    input  logic [PW-1:0] mult_prod,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    input  logic          out_ready
);

    localparam int TW = $clog2(NTAPS);

    state_e        state_q, state_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          coef_err_q, coef_err_d;
    logic [CW-1:0] coef_q [NTAPS];
    logic [CW-1:0] coef_d [NTAPS];

    logic          idle;
    logic          mac;
    logic          accept;
    logic          addr_ok;
    logic [DW-1:0] dl_rd;
    logic [AW-1:0] sum;

    assign idle    = (state_q == ST_IDLE);
    assign mac     = (state_q == ST_MAC);
    assign accept  = idle & in_valid;
    assign addr_ok = ({1'b0, coef_addr} < 5'(NTAPS));
    assign sum     = acc_q + AW'(mult_prod);

    fir_delay_line #(
        .N (NTAPS),
        .W (DW)
    ) u_dl (
        .clk      (clk),
        .clr      (rst),
        .shift_en (accept),
        .din      (in_sample),
        .rd_idx   (tap_q),
        .rd_data  (dl_rd)
    );

    // Operands are forced to zero outside MAC so the multiplier sees quiet inputs.
    assign mult_sample = mac ? dl_rd : '0;
    assign mult_coeff  = mac ? coef_q[tap_q] : '0;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        coef_err_d  = 1'b0;
        coef_d      = coef_q;

        // Writes only land while idle; out-of-range addresses vanish silently.
        if (coef_we) begin
            if (idle) begin
                if (addr_ok) coef_d[coef_addr[TW-1:0]] = coef_wdata;
            end else begin
                coef_err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = sum;
                tap_d = tap_q + 1'b1;
                if (tap_q == TW'(NTAPS - 1)) begin
                    out_data_d  = sum;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            coef_err_q  <= coef_err_d;
            coef_q      <= coef_d;
        end
    end

    assign in_ready  = idle;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign coef_err  = coef_err_q;

endmodule
